// File: rtl/fp_norm_pkg.sv
// Shared types and constants for the FP add/sub normalization controller.
package fp_norm_pkg;

  localparam int MANT_W = 24;
  localparam int EXP_W  = 8;
  localparam int LZC_W  = 5;

  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  localparam int FLAG_OVF  = 2;
  localparam int FLAG_UNF  = 1;
  localparam int FLAG_ZERO = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // A nonzero mantissa can have at most MANT_W-1 leading zeros.
  function automatic logic [LZC_W-1:0] clamp_lzc(input logic [LZC_W-1:0] lzc);
    if (lzc > LZC_W'(MANT_W - 1)) return LZC_W'(MANT_W - 1);
    return lzc;
  endfunction

endpackage

// File: rtl/fp_norm_ctrl_if.sv
// Operand/result bus of the normalization controller.
// Both sides use valid/ready: a transfer happens on a rising clk edge where
// valid and ready are both high; valid holds its payload stable until then.
interface fp_norm_ctrl_if;
  import fp_norm_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [MANT_W:0]   in_mant;
  logic [EXP_W-1:0]  in_exp;
  logic              in_sign;
  logic [LZC_W-1:0]  lzc;

  logic              out_valid;
  logic              out_ready;
  logic [MANT_W-1:0] out_mant;
  logic [EXP_W-1:0]  out_exp;
  logic              out_sign;
  logic              out_guard;
  logic [2:0]        out_flags;
  logic              busy;

  modport master (
    output in_valid, in_mant, in_exp, in_sign, lzc, out_ready,
    input  in_ready, out_valid, out_mant, out_exp, out_sign, out_guard,
           out_flags, busy
  );

  modport slave (
    input  in_valid, in_mant, in_exp, in_sign, lzc, out_ready,
    output in_ready, out_valid, out_mant, out_exp, out_sign, out_guard,
           out_flags, busy
  );

endinterface

// File: rtl/fp_norm_step_shifter.sv
// Combinational left shift by min(amt, MAX_STEP); reports the distance used.
module fp_norm_step_shifter #(
  parameter int W        = 24,
  parameter int AMT_W    = 5,
  parameter int MAX_STEP = 8
) (
  input  logic [W-1:0]     din,
  input  logic [AMT_W-1:0] amt,
  output logic [W-1:0]     dout,
  output logic [AMT_W-1:0] step
);

  localparam logic [AMT_W-1:0] MAX_AMT = AMT_W'(MAX_STEP);

  always_comb begin
    step = (amt > MAX_AMT) ? MAX_AMT : amt;
    dout = din << step;
  end

endmodule

// File: rtl/fp_norm_ctrl.sv
// Multi-cycle normalization controller (IDLE -> [SHIFT] -> DONE).
// FP_NORM_GUARD_EN: register the bit lost on a carry right-shift to out_guard.
module fp_norm_ctrl
  import fp_norm_pkg::*;
#(
  parameter int MAX_STEP = 8
) (
  input  logic             clk,
  input  logic             rst,
  fp_norm_ctrl_if.slave    bus,
  output state_t           dbg_state
);

  state_t              state_q, state_d;
  logic [MANT_W-1:0]   mant_q, mant_d;
  logic [EXP_W-1:0]    exp_q, exp_d;
  logic                sign_q, sign_d;
  logic                guard_q, guard_d;
  logic [2:0]          flags_q, flags_d;
  logic [LZC_W-1:0]    rem_q, rem_d;

  logic [MANT_W-1:0]   shift_mant;
  logic [LZC_W-1:0]    step;
  logic [LZC_W-1:0]    lzc_c;
  logic [LZC_W-1:0]    target;
  logic [EXP_W-1:0]    exp_inc;

  fp_norm_step_shifter #(
    .W       (MANT_W),
    .AMT_W   (LZC_W),
    .MAX_STEP(MAX_STEP)
  ) u_shifter (
    .din (mant_q),
    .amt (rem_q),
    .dout(shift_mant),
    .step(step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mant_q  <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      guard_q <= 1'b0;
      flags_q <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      mant_q  <= mant_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      guard_q <= guard_d;
      flags_q <= flags_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mant_d  = mant_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    guard_d = guard_q;
    flags_d = flags_q;
    rem_d   = rem_q;
    lzc_c   = clamp_lzc(bus.lzc);
    target  = '0;
    exp_inc = bus.in_exp + EXP_W'(1);

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sign_d  = bus.in_sign;
          guard_d = 1'b0;
          flags_d = '0;
          rem_d   = '0;
          state_d = DONE;
          if (bus.in_mant[MANT_W]) begin
            mant_d = bus.in_mant[MANT_W:1];
            exp_d  = exp_inc;
`ifdef FP_NORM_GUARD_EN
            guard_d = bus.in_mant[0];
`endif
            if (exp_inc == EXP_MAX) begin
              mant_d            = '0;
              flags_d[FLAG_OVF] = 1'b1;
            end
          end else if (bus.in_mant == '0) begin
            mant_d             = '0;
            exp_d              = '0;
            flags_d[FLAG_ZERO] = 1'b1;
          end else if (bus.in_exp == '0) begin
            mant_d = bus.in_mant[MANT_W-1:0];
            exp_d  = '0;
          end else begin
            mant_d = bus.in_mant[MANT_W-1:0];
            exp_d  = bus.in_exp;
            // Shifting past exponent 1 would go negative: stop there and denormalize.
            if (EXP_W'(lzc_c) < bus.in_exp) begin
              target = lzc_c;
            end else begin
              target            = LZC_W'(bus.in_exp - EXP_W'(1));
              flags_d[FLAG_UNF] = 1'b1;
            end
            if (target == '0) begin
              if (flags_d[FLAG_UNF]) exp_d = '0;
            end else begin
              rem_d   = target;
              state_d = SHIFT;
            end
          end
        end
      end

      SHIFT: begin
        mant_d = shift_mant;
        exp_d  = exp_q - EXP_W'(step);
        rem_d  = rem_q - step;
        if (rem_q == step) begin
          state_d = DONE;
          if (flags_q[FLAG_UNF]) exp_d = '0;
        end
      end

      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == SHIFT) || (state_q == DONE);
  assign bus.out_mant  = mant_q;
  assign bus.out_exp   = exp_q;
  assign bus.out_sign  = sign_q;
  assign bus.out_guard = guard_q;
  assign bus.out_flags = flags_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_fp_norm_ctrl.sv
// Directed vector bench for fp_norm_ctrl (MAX_STEP = 8).
module tb_fp_norm_ctrl;
  import fp_norm_pkg::*;

`ifdef FP_NORM_GUARD_EN
  localparam logic G = 1'b1;
`else
  localparam logic G = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [24:0] mant;
    logic [7:0]  exp;
    logic        sign;
    logic [4:0]  lzc;
    logic [23:0] e_mant;
    logic [7:0]  e_exp;
    logic        e_guard;
    logic [2:0]  e_flags;
    int          e_lat;
  } vec_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t dbg_state;
  int     n_checks = 0;
  int     n_pass = 0;
  logic [MANT_W-1:0] exp_q[$];
  vec_t   vecs[12];

  fp_norm_ctrl_if bus();

  fp_norm_ctrl #(.MAX_STEP(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // driver: present one operand, wait for out_valid, compare everything
  task automatic apply(input vec_t v);
    int lat;
    logic [MANT_W-1:0] em;
    @(negedge clk);
    check({v.name, " in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_mant  = v.mant;
    bus.in_exp   = v.exp;
    bus.in_sign  = v.sign;
    bus.lzc      = v.lzc;
    exp_q.push_back(v.e_mant);
    @(posedge clk);
    lat = 1;
    #1;
    bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 64) begin
      @(posedge clk);
      lat++;
      #1;
    end
    em = exp_q.pop_front();
    check({v.name, " latency"}, 32'(lat), 32'(v.e_lat));
    check({v.name, " out_mant"}, 32'(bus.out_mant), 32'(em));
    check({v.name, " out_exp"}, 32'(bus.out_exp), 32'(v.e_exp));
    check({v.name, " out_sign"}, 32'(bus.out_sign), 32'(v.sign));
    check({v.name, " out_guard"}, 32'(bus.out_guard), 32'(v.e_guard));
    check({v.name, " out_flags"}, 32'(bus.out_flags), 32'(v.e_flags));
  endtask

  task automatic release_out(input string name);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({name, " idle out_valid"}, 32'(bus.out_valid), 32'd0);
    check({name, " idle in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_mant   = '0;
    bus.in_exp    = '0;
    bus.in_sign   = 1'b0;
    bus.lzc       = '0;
    bus.out_ready = 1'b0;

    vecs[0]  = '{"norm",      25'h0800000, 8'h80, 1'b0, 5'd0,  24'h800000, 8'h80, 1'b0, 3'b000, 1};
    vecs[1]  = '{"carry",     25'h1800001, 8'h80, 1'b1, 5'd0,  24'hC00000, 8'h81, G,    3'b000, 1};
    vecs[2]  = '{"multi",     25'h0000008, 8'h80, 1'b0, 5'd20, 24'h800000, 8'h6C, 1'b0, 3'b000, 4};
    vecs[3]  = '{"underflow", 25'h0000100, 8'h05, 1'b1, 5'd15, 24'h001000, 8'h00, 1'b0, 3'b010, 2};
    vecs[4]  = '{"overflow",  25'h1000000, 8'hFE, 1'b0, 5'd0,  24'h000000, 8'hFF, 1'b0, 3'b100, 1};
    vecs[5]  = '{"zero",      25'h0000000, 8'h55, 1'b0, 5'd7,  24'h000000, 8'h00, 1'b0, 3'b001, 1};
    vecs[6]  = '{"denorm_in", 25'h0001234, 8'h00, 1'b1, 5'd11, 24'h001234, 8'h00, 1'b0, 3'b000, 1};
    vecs[7]  = '{"lzc_clamp", 25'h0000001, 8'h80, 1'b0, 5'd31, 24'h800000, 8'h69, 1'b0, 3'b000, 4};
    vecs[8]  = '{"two_full",  25'h0000080, 8'h40, 1'b0, 5'd16, 24'h800000, 8'h30, 1'b0, 3'b000, 3};
    vecs[9]  = '{"unf_exp1",  25'h0400000, 8'h01, 1'b0, 5'd1,  24'h400000, 8'h00, 1'b0, 3'b010, 1};
    vecs[10] = '{"carry_fd",  25'h1FFFFFF, 8'hFD, 1'b1, 5'd0,  24'hFFFFFF, 8'hFE, G,    3'b000, 1};
    vecs[11] = '{"step9",     25'h0004000, 8'h10, 1'b0, 5'd9,  24'h800000, 8'h07, 1'b0, 3'b000, 3};

    repeat (3) @(posedge clk);
    #1;
    check("rst in_ready", 32'(bus.in_ready), 32'd1);
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst out_mant", 32'(bus.out_mant), 32'd0);
    check("rst out_exp", 32'(bus.out_exp), 32'd0);
    check("rst out_flags", 32'(bus.out_flags), 32'd0);
    check("rst busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      apply(vecs[i]);
      release_out(vecs[i].name);
    end

    // backpressure: result must hold while out_ready stays low
    apply(vecs[2]);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("bp out_valid", 32'(bus.out_valid), 32'd1);
      check("bp in_ready", 32'(bus.in_ready), 32'd0);
      check("bp out_mant", 32'(bus.out_mant), 32'h800000);
      check("bp out_exp", 32'(bus.out_exp), 32'h6C);
    end
    release_out("bp");

    // reset in the middle of a multi-cycle shift
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_mant  = vecs[7].mant;
    bus.in_exp   = vecs[7].exp;
    bus.in_sign  = 1'b1;
    bus.lzc      = vecs[7].lzc;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("mid busy", 32'(bus.busy), 32'd1);
    check("mid state", 32'(dbg_state), 32'(SHIFT));
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst state", 32'(dbg_state), 32'(IDLE));
    check("arst out_valid", 32'(bus.out_valid), 32'd0);
    check("arst in_ready", 32'(bus.in_ready), 32'd1);
    check("arst out_mant", 32'(bus.out_mant), 32'd0);
    check("arst out_sign", 32'(bus.out_sign), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    apply(vecs[3]);
    release_out("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
